// File: rtl/dds_pkg.sv
// Shared constants, quadrant encodings and the pipeline tag type for the
// DDS phase sequencer and any other consumer of the quarter-wave CORDIC core.
package dds_pkg;

   localparam int PHASE_W  = 8;    // sample phase resolution (bits)
   localparam int QW_PTS   = 64;   // quarter-wave points; legal core addresses 0..QW_PTS
   localparam int CORE_LAT = 9;    // CORDIC core address-to-value latency (cycles)

   // Quadrant of a PHASE_W-bit phase (its top two bits)
   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   // Side-band information that travels alongside a core lookup
   typedef struct packed {
      logic               valid;
      logic               neg;
      logic [PHASE_W-1:0] phase;
   } tag_t;

   function automatic quad_e phase_quad(input logic [PHASE_W-1:0] p);
      return quad_e'(p[PHASE_W-1 -: 2]);
   endfunction

   // Lower half of the wave: the core magnitude must be negated
   function automatic logic quad_neg(input quad_e q);
      return (q == Q2) || (q == Q3);
   endfunction

   // Falling quarters: the quarter-wave table is read backwards
   function automatic logic quad_mirror(input quad_e q);
      return (q == Q1) || (q == Q3);
   endfunction

endpackage

// File: rtl/dds_tag_pipe.sv
// Parameterised-depth shift register of CORDIC lookup tags. It advances every
// cycle so that its output lines up with the value returned by the core.
module dds_tag_pipe
   import dds_pkg::*;
#(
   parameter int DEPTH = dds_pkg::CORE_LAT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  tag_t tag_i,
   output tag_t tag_o
);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         tag_t stage_q;
         tag_t stage_d;

         if (gi == 0) begin : g_head
            assign stage_d = tag_i;
         end else begin : g_link
            assign stage_d = g_stage[gi-1].stage_q;
         end

         // One tag stage; a clear drops everything that is in flight
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               stage_q <= '0;
            end else if (clr_i) begin
               stage_q <= '0;
            end else begin
               stage_q <= stage_d;
            end
         end
      end
   endgenerate

   assign tag_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/dds_cordic_sequencer.sv
// DDS phase-accumulator controller for the quarter-wave CORDIC sine core:
// advances the phase, folds it onto the 0..64 table address, carries the
// quadrant sign through the core latency and rebuilds a signed full-wave sample.
module dds_cordic_sequencer #(
   parameter int ACC_W    = 16,
   parameter int CORE_LAT = 9,
   parameter int ADDR_W   = 7,
   parameter int VAL_W    = 7
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              en,
   input  logic              clr,
   input  logic              freq_ld,
   input  logic [ACC_W-1:0]  freq_word,
   input  logic [7:0]        phase_off,
   output logic [ADDR_W-1:0] cordic_addr,
   input  logic [VAL_W-1:0]  cordic_value,
   output logic [VAL_W:0]    sine_out,
   output logic              sine_valid,
   output logic [7:0]        phase_out
);

   import dds_pkg::*;

   // Accumulator, frequency word and core address
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   freq_q, freq_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;

   // Phase fold
   logic [PHASE_W-1:0] phase_c;
   quad_e              quad_c;
   logic               neg_c;
   logic [ADDR_W-1:0]  idx_c;
   logic [ADDR_W-1:0]  fold_addr_c;

   // Tag pipeline
   tag_t               tag_in_c;
   tag_t               tag_out_c;

   // Output stage
   logic [VAL_W:0]     mag_c;
   logic [VAL_W:0]     signed_mag_c;
   logic [VAL_W:0]     sine_q, sine_d;
   logic               valid_q, valid_d;
   logic [PHASE_W-1:0] phase_out_q, phase_out_d;

   // Sample phase = accumulator top byte plus the static offset, mod 256
   assign phase_c     = acc_q[ACC_W-1 -: PHASE_W] + phase_off;
   assign quad_c      = phase_quad(phase_c);
   assign neg_c       = quad_neg(quad_c);
   assign idx_c       = ADDR_W'(phase_c[PHASE_W-3:0]);
   // Mirrored quarters read 64-i so the address stays within 0..64
   assign fold_addr_c = quad_mirror(quad_c) ? (ADDR_W'(QW_PTS) - idx_c) : idx_c;

   // Accumulator/address next state; clr wins over en, freq loads independently
   always_comb begin
      acc_d  = acc_q;
      addr_d = addr_q;
      freq_d = freq_ld ? freq_word : freq_q;
      if (clr) begin
         acc_d  = '0;
         addr_d = '0;
      end else if (en) begin
         acc_d  = acc_q + freq_q;
         addr_d = fold_addr_c;
      end
   end

   // Phase state registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         acc_q  <= '0;
         freq_q <= '0;
         addr_q <= '0;
      end else begin
         acc_q  <= acc_d;
         freq_q <= freq_d;
         addr_q <= addr_d;
      end
   end

   // Tag issued alongside every address; a disabled cycle inserts a bubble
   always_comb begin
      tag_in_c       = '0;
      tag_in_c.valid = en & ~clr;
      tag_in_c.neg   = neg_c;
      tag_in_c.phase = phase_c;
   end

   dds_tag_pipe #(
      .DEPTH (CORE_LAT)
   ) u_tag_pipe (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .clr_i  (clr),
      .tag_i  (tag_in_c),
      .tag_o  (tag_out_c)
   );

   // Zero-extend before negating so +127 maps to -127 and 0 never becomes -0
   assign mag_c        = {1'b0, cordic_value};
   assign signed_mag_c = tag_out_c.neg ? (~mag_c + 1'b1) : mag_c;

   // Output next state: capture only valid aligned tags, otherwise hold
   always_comb begin
      valid_d     = 1'b0;
      sine_d      = sine_q;
      phase_out_d = phase_out_q;
      if (!clr && tag_out_c.valid) begin
         valid_d     = 1'b1;
         sine_d      = signed_mag_c;
         phase_out_d = tag_out_c.phase;
      end
   end

   // Output sample registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q     <= 1'b0;
         sine_q      <= '0;
         phase_out_q <= '0;
      end else begin
         valid_q     <= valid_d;
         sine_q      <= sine_d;
         phase_out_q <= phase_out_d;
      end
   end

   assign cordic_addr = addr_q;
   assign sine_out    = sine_q;
   assign sine_valid  = valid_q;
   assign phase_out   = phase_out_q;

endmodule

// File: tb/tb_dds_cordic_sequencer.sv
// Scoreboard bench for dds_cordic_sequencer: stimulus pushes expected samples
// (with the edge they are due on), a negedge monitor pops and compares them.
module tb_dds_cordic_sequencer;

   localparam int ACC_W    = 16;
   localparam int CORE_LAT = 9;
   localparam int ADDR_W   = 7;
   localparam int VAL_W    = 7;

   logic              CLK       = 1'b0;
   logic              RESET     = 1'b0;
   logic              en        = 1'b0;
   logic              clr       = 1'b0;
   logic              freq_ld   = 1'b0;
   logic [ACC_W-1:0]  freq_word = '0;
   logic [7:0]        phase_off = '0;
   logic [ADDR_W-1:0] cordic_addr;
   logic [VAL_W-1:0]  cordic_value;
   logic [VAL_W:0]    sine_out;
   logic              sine_valid;
   logic [7:0]        phase_out;

   dds_cordic_sequencer #(
      .ACC_W    (ACC_W),
      .CORE_LAT (CORE_LAT),
      .ADDR_W   (ADDR_W),
      .VAL_W    (VAL_W)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .en           (en),
      .clr          (clr),
      .freq_ld      (freq_ld),
      .freq_word    (freq_word),
      .phase_off    (phase_off),
      .cordic_addr  (cordic_addr),
      .cordic_value (cordic_value),
      .sine_out     (sine_out),
      .sine_valid   (sine_valid),
      .phase_out    (phase_out)
   );

   always #5 CLK = ~CLK;

   // Core stub: linear table 127*a/64. The DUT's cordic_addr register is the
   // first of the core's nine cycles; eight more stages follow here.
   function automatic logic [6:0] stub_lut(input logic [6:0] a);
      int v;
      v = (int'(a) * 127) / 64;
      return v[6:0];
   endfunction

   logic [6:0] stub_q [8];
   always @(posedge CLK) begin
      stub_q[0] <= stub_lut(cordic_addr);
      for (int k = 1; k < 8; k++) stub_q[k] <= stub_q[k-1];
   end
   assign cordic_value = stub_q[7];

   // Scoreboard
   typedef struct packed {
      int         due;
      logic [7:0] p;
      logic [7:0] s;
   } exp_t;

   exp_t sb[$];
   exp_t mon_x;
   int   edge_cnt  = 0;
   int   tests     = 0;
   int   fails     = 0;
   int   valid_cnt = 0;

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
      end
   endtask

   // Monitor: every presented sample must match the head of the scoreboard
   always @(negedge CLK) begin
      if (RESET) begin
         if (sine_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               mon_x = sb.pop_front();
               check("latency_edge", edge_cnt, mon_x.due);
               check("phase_out", int'(phase_out), int'(mon_x.p));
               check("sine_out", int'(sine_out), int'(mon_x.s));
               $display("[TB] sample edge=%0d phase=%02h sine=%02h exp_phase=%02h exp_sine=%02h",
                        edge_cnt, phase_out, sine_out, mon_x.p, mon_x.s);
            end
         end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
            mon_x = sb.pop_front();
            check("missing_valid", 0, 1);
         end
      end
   end

   // Reference model of accumulator, frequency and address
   logic [15:0] model_acc  = '0;
   logic [15:0] model_freq = '0;
   logic [6:0]  model_addr = '0;
   logic        use_hand   = 1'b0;
   logic [7:0]  hand_p     = '0;
   logic [7:0]  hand_s     = '0;
   logic [6:0]  hand_a     = '0;

   function automatic logic [6:0] m_fold(input logic [7:0] p);
      if (p[6]) return 7'd64 - {1'b0, p[5:0]};
      return {1'b0, p[5:0]};
   endfunction

   function automatic logic [7:0] m_sine(input logic [7:0] p);
      logic [7:0] m;
      m = {1'b0, stub_lut(m_fold(p))};
      return p[7] ? -m : m;
   endfunction

   // Drive one clock edge's worth of inputs and record what it should produce
   task automatic drive(input logic e, input logic c, input logic ld, input logic [15:0] w);
      logic [7:0] p;
      exp_t       x;
      int         nxt;
      en        = e;
      clr       = c;
      freq_ld   = ld;
      freq_word = w;
      nxt       = edge_cnt + 1;
      p         = model_acc[15:8] + phase_off;
      if (c) begin
         for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due >= nxt) sb.delete(k);
         end
         model_acc  = '0;
         model_addr = '0;
      end else if (e) begin
         x.due = nxt + CORE_LAT;
         x.p   = use_hand ? hand_p : p;
         x.s   = use_hand ? hand_s : m_sine(p);
         sb.push_back(x);
         model_acc  = model_acc + model_freq;
         model_addr = use_hand ? hand_a : m_fold(p);
      end
      if (ld) model_freq = w;
      @(posedge CLK);
      #1;
      check("cordic_addr", int'(cordic_addr), int'(model_addr));
   endtask

   task automatic drive_hand(input logic [7:0] p, input logic [7:0] s, input logic [6:0] a);
      use_hand = 1'b1;
      hand_p   = p;
      hand_s   = s;
      hand_a   = a;
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      use_hand = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 40) begin
         drive(1'b0, 1'b0, 1'b0, 16'h0000);
         n++;
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      int base;
      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      check("rst_sine_valid", int'(sine_valid), 0);
      check("rst_sine_out", int'(sine_out), 0);
      check("rst_phase_out", int'(phase_out), 0);
      check("rst_cordic_addr", int'(cordic_addr), 0);
      RESET = 1'b1;

      // Latency: freq 0x0400, continuous enable, phases 00,04,08,...
      drive(1'b0, 1'b0, 1'b1, 16'h0400);
      repeat (14) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drain();

      // Fold map with hand-computed addresses and samples (clr + load together)
      drive(1'b0, 1'b1, 1'b1, 16'h0000);
      phase_off = 8'h40; drive_hand(8'h40, 8'h7F, 7'd64);
      phase_off = 8'h80; drive_hand(8'h80, 8'h00, 7'd0);
      phase_off = 8'hC4; drive_hand(8'hC4, 8'h89, 7'd60);
      drain();

      // Accumulator wrap with freq 0xFFFF: phases 00,FF,FF,...
      phase_off = 8'h00;
      drive(1'b0, 1'b1, 1'b1, 16'hFFFF);
      repeat (6) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drain();

      // Gated enable 1,0,1,1,0 -> three samples
      drive(1'b0, 1'b1, 1'b1, 16'h0400);
      base = valid_cnt;
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      drain();
      check("gated_pulses", valid_cnt - base, 3);

      // clr on the fifth enabled cycle discards earlier samples
      phase_off = 8'h10;
      drive(1'b0, 1'b1, 1'b0, 16'h0000);
      base = valid_cnt;
      repeat (4) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      repeat (3) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drain();
      check("clr_pulses", valid_cnt - base, 3);

      // Frequency change mid-run: step 4 becomes 8 one sample after the load
      phase_off = 8'h00;
      drive(1'b0, 1'b1, 1'b1, 16'h0400);
      repeat (3) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 1'b1, 16'h0800);
      repeat (3) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drain();

      // Async reset mid-stream discards in-flight samples
      repeat (12) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      RESET      = 1'b0;
      sb.delete();
      model_acc  = '0;
      model_freq = '0;
      model_addr = '0;
      #1;
      check("arst_sine_valid", int'(sine_valid), 0);
      check("arst_sine_out", int'(sine_out), 0);
      check("arst_phase_out", int'(phase_out), 0);
      check("arst_cordic_addr", int'(cordic_addr), 0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 16'h0400);
      repeat (12) drive(1'b1, 1'b0, 1'b0, 16'h0000);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Bound on total run time
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

endmodule
